// File: rtl/mem_sequencer_pkg.sv
// mem_seq_pkg: shared types and constants for the mem_sequencer block.
// Holds the sequencer state encoding, the full-word byte-enable constant,
// the byte-lane index type and the default bus wait limit.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_DATA,
    ST_COMMIT,
    ST_HALT
  } state_t;

  localparam logic [3:0] BE_WORD         = 4'b1111;
  localparam int         DEFAULT_TIMEOUT = 16;

  // Byte position within a 32-bit little-endian word.
  typedef logic [1:0] lane_t;

  // One-hot byte enable for a single lane.
  function automatic logic [3:0] lane_be(input lane_t lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/mem_sequencer_if.sv
// mem_sequencer_if: single-ported, variable-latency memory bus.
// The sequencer drives the request side through the master modport; the
// memory (or a bench model) answers through the slave modport.
interface mem_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_sequencer_byte_lane.sv
// byte_lane_unit: purely combinational byte steering for the sequencer.
// Store side: one-hot byte enable and byte replication across the word.
// Load side: selects one byte lane and zero-extends it, or passes the word.
module byte_lane_unit
  import mem_seq_pkg::*;
(
  input  lane_t       lane,
  input  logic        byte_store,
  input  logic [31:0] store_data,
  input  logic        byte_load,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_be,
  output logic [31:0] wdata,
  output logic [31:0] load_val
);

  logic [7:0] sel_byte;

  // Lane steering for both directions.
  always_comb begin
    byte_be  = lane_be(lane);
    wdata    = byte_store ? {4{store_data[7:0]}} : store_data;
    sel_byte = rdata[{lane, 3'b000} +: 8];
    load_val = byte_load ? {24'h0, sel_byte} : rdata;
  end

endmodule

// File: rtl/mem_sequencer.sv
// mem_sequencer: multi-cycle fetch/decode/data/commit sequencer that shares
// one single-ported memory between instruction fetch and data access, and
// pulses step once per completed instruction.
// Optional feature: define MEM_TIMEOUT_EN to abort any bus access that waits
// TIMEOUT cycles, raising the sticky bus_error and halting the core.
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       store_data,
  input  logic              mem_read,
  input  logic              word_we,
  input  logic              byte_we,
  input  logic              byte_load,
  input  logic              except_in,
  output logic [31:0]       inst,
  output logic [31:0]       load_data,
  output logic              step,
  output logic              halted,
  output logic              bus_error,
  mem_sequencer_if.master   bus
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        inst_en, load_en, err_set;
  logic        accept, timeout_hit;
  logic        store_op, mem_op, misaligned;
  logic [3:0]  lane_byte_be;
  logic [31:0] lane_wdata, lane_load;
  logic [31:0] inst_q, load_q;
  logic        err_q;

  assign accept     = req_q && bus.mem_ready;
  assign store_op   = word_we || byte_we;
  assign mem_op     = mem_read || store_op;
  assign misaligned = (data_addr[1:0] != 2'b00) && ((mem_read && !byte_load) || word_we);

  byte_lane_unit u_lane (
    .lane       (data_addr[1:0]),
    .byte_store (byte_we),
    .store_data (store_data),
    .byte_load  (byte_load),
    .rdata      (bus.mem_rdata),
    .byte_be    (lane_byte_be),
    .wdata      (lane_wdata),
    .load_val   (lane_load)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_q;

  // Wait counter: idle while no request is open, counts unanswered request cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
    end else if (!req_q || bus.mem_ready) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_q + 1'b1;
    end
  end

  assign timeout_hit = req_q && !bus.mem_ready && (wait_q == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State and request registers; reset drops the request immediately.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  // Next-state, request and capture-enable decode.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    inst_en = 1'b0;
    load_en = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (!req_q) begin
          req_d = 1'b1;                     // first fetch after reset
        end else if (accept) begin
          inst_en = 1'b1;
          req_d   = 1'b0;
          state_d = ST_DECODE;
        end else if (timeout_hit) begin
          err_set = 1'b1;
          req_d   = 1'b0;
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (except_in || (mem_op && misaligned)) begin
          state_d = ST_HALT;
        end else if (mem_op) begin
          req_d   = 1'b1;
          state_d = ST_DATA;
        end else begin
          state_d = ST_COMMIT;
        end
      end
      ST_DATA: begin
        if (accept) begin
          load_en = mem_read;
          req_d   = 1'b0;
          state_d = ST_COMMIT;
        end else if (timeout_hit) begin
          err_set = 1'b1;
          req_d   = 1'b0;
          state_d = ST_HALT;
        end
      end
      ST_COMMIT: begin
        req_d   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        req_d = 1'b0;
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_HALT;
      end
    endcase
  end

  // Instruction, load result and sticky error registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inst_q <= '0;
      load_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (inst_en) inst_q <= bus.mem_rdata;
      if (load_en) load_q <= lane_load;
      if (err_set) err_q  <= 1'b1;
    end
  end

  // Bus drive: quiet whenever no request is open, otherwise fetch or data attributes.
  always_comb begin
    bus.mem_req   = req_q;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    if (req_q) begin
      if (state_q == ST_DATA) begin
        bus.mem_addr  = data_addr & ALIGN_MASK;
        bus.mem_we    = store_op;
        bus.mem_be    = byte_we ? lane_byte_be : BE_WORD;
        bus.mem_wdata = store_op ? lane_wdata : '0;
      end else begin
        bus.mem_addr = pc & ALIGN_MASK;
        bus.mem_be   = BE_WORD;
      end
    end
  end

  assign inst      = inst_q;
  assign load_data = load_q;
  assign step      = (state_q == ST_COMMIT);
  assign halted    = (state_q == ST_HALT);
  assign bus_error = err_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: directed bench for mem_sequencer. A table of single
// instructions (each started from reset, memory answering with zero wait
// states) is followed by hand-written wait-state/reset and timeout sequences.
module tb_mem_sequencer;

  logic        clock;
  logic        reset;
  logic [31:0] pc, data_addr, store_data;
  logic        mem_read, word_we, byte_we, byte_load, except_in;
  logic [31:0] inst, load_data;
  logic        step, halted, bus_error;

  int total = 0;
  int bad   = 0;

  mem_sequencer_if #(.ADDR_W(32)) bus ();

  mem_sequencer #(.ADDR_W(32), .TIMEOUT(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .pc         (pc),
    .data_addr  (data_addr),
    .store_data (store_data),
    .mem_read   (mem_read),
    .word_we    (word_we),
    .byte_we    (byte_we),
    .byte_load  (byte_load),
    .except_in  (except_in),
    .inst       (inst),
    .load_data  (load_data),
    .step       (step),
    .halted     (halted),
    .bus_error  (bus_error),
    .bus        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc, daddr, sdata;
    logic        rd, wwe, bwe, bload, exc;
    logic [31:0] iword, dword;
    int          exp_step;
    logic        exp_halt;
    logic [15:0] exp_mask;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic        exp_we;
    logic [31:0] exp_wdata, exp_load;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench 1 time unit after the edge following reset release:
  // the idle FETCH cycle with no request open.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t        v;
    int          reqs, step_cyc, post;
    logic [15:0] mask;
    logic [31:0] f_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        f_we, d_we;
    v = vecs[i];
    reqs = 0; step_cyc = 0; post = 0; mask = '0;
    f_addr = '0; f_we = 1'b0; d_addr = '0; d_be = '0; d_we = 1'b0; d_wdata = '0;
    pc = v.pc; data_addr = v.daddr; store_data = v.sdata;
    mem_read = v.rd; word_we = v.wwe; byte_we = v.bwe; byte_load = v.bload; except_in = v.exc;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = '0;
    do_reset();
    tick();
    for (int c = 1; c <= 8; c++) begin
      if (bus.mem_req) begin
        mask[c] = 1'b1;
        reqs++;
        if (reqs == 1) begin
          f_addr = bus.mem_addr; f_we = bus.mem_we;
          bus.mem_rdata = v.iword;
        end else begin
          d_addr = bus.mem_addr; d_be = bus.mem_be; d_we = bus.mem_we; d_wdata = bus.mem_wdata;
          bus.mem_rdata = v.dword;
        end
      end
      if (step) begin
        step_cyc = c;
        break;
      end
      if (halted) break;
      tick();
    end
    check($sformatf("v%0d fetch_addr", i), f_addr, v.pc & 32'hFFFF_FFFC);
    check($sformatf("v%0d fetch_we", i), {31'b0, f_we}, 32'd0);
    check($sformatf("v%0d inst", i), inst, v.iword);
    check($sformatf("v%0d req_cycles", i), {16'b0, mask}, {16'b0, v.exp_mask});
    check($sformatf("v%0d step_cycle", i), step_cyc, v.exp_step);
    check($sformatf("v%0d halted", i), {31'b0, halted}, {31'b0, v.exp_halt});
    check($sformatf("v%0d load_data", i), load_data, v.exp_load);
    check($sformatf("v%0d bus_error", i), {31'b0, bus_error}, 32'd0);
    if ((v.rd || v.wwe || v.bwe) && !v.exp_halt) begin
      check($sformatf("v%0d data_addr", i), d_addr, v.exp_addr);
      check($sformatf("v%0d data_be", i), {28'b0, d_be}, {28'b0, v.exp_be});
      check($sformatf("v%0d data_we", i), {31'b0, d_we}, {31'b0, v.exp_we});
      check($sformatf("v%0d data_wdata", i), d_wdata, v.exp_wdata);
    end
    if (v.exp_halt) begin
      for (int k = 0; k < 6; k++) begin
        tick();
        if (bus.mem_req || step || !halted) post++;
      end
      check($sformatf("v%0d halt_quiet", i), post, 0);
    end else begin
      tick();
      check($sformatf("v%0d step_one_cycle", i), {31'b0, step}, 32'd0);
      check($sformatf("v%0d next_fetch_req", i), {31'b0, bus.mem_req}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int step_cyc, unstable, nreq;
    reset = 1'b1;
    pc = '0; data_addr = '0; store_data = '0;
    mem_read = 0; word_we = 0; byte_we = 0; byte_load = 0; except_in = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    //            pc          daddr       sdata        rd wwe bwe bld exc iword        dword        step hlt mask     addr        be    we wdata        load
    vecs[0] = '{32'h100, 32'h0,    32'h0,        0, 0, 0, 0, 0, 32'h01095020, 32'h0,        3, 0, 16'h0002, 32'h0,    4'h0, 0, 32'h0,        32'h0};
    vecs[1] = '{32'h104, 32'h1003, 32'h0,        1, 0, 0, 1, 0, 32'h90A20003, 32'hAABBCCDD, 4, 0, 16'h000A, 32'h1000, 4'hF, 0, 32'h0,        32'h000000AA};
    vecs[2] = '{32'h108, 32'h2000, 32'h0,        1, 0, 0, 0, 0, 32'h8C430000, 32'h11223344, 4, 0, 16'h000A, 32'h2000, 4'hF, 0, 32'h0,        32'h11223344};
    vecs[3] = '{32'h10C, 32'h2001, 32'h12345677, 0, 0, 1, 0, 0, 32'hA0A70001, 32'h0,        4, 0, 16'h000A, 32'h2000, 4'h2, 1, 32'h77777777, 32'h0};
    vecs[4] = '{32'h110, 32'h3004, 32'hDEADBEEF, 0, 1, 0, 0, 0, 32'hAC430004, 32'h0,        4, 0, 16'h000A, 32'h3004, 4'hF, 1, 32'hDEADBEEF, 32'h0};
    vecs[5] = '{32'h114, 32'h1005, 32'h0,        1, 0, 0, 1, 0, 32'h90A20005, 32'hAABBCCDD, 4, 0, 16'h000A, 32'h1004, 4'hF, 0, 32'h0,        32'h000000CC};
    vecs[6] = '{32'h118, 32'h0,    32'h0,        0, 0, 0, 0, 1, 32'hFC000000, 32'h0,        0, 1, 16'h0002, 32'h0,    4'h0, 0, 32'h0,        32'h0};
    vecs[7] = '{32'h11C, 32'h3002, 32'h0,        1, 0, 0, 0, 0, 32'h8C430002, 32'h0,        0, 1, 16'h0002, 32'h0,    4'h0, 0, 32'h0,        32'h0};
    vecs[8] = '{32'h120, 32'h0011, 32'h55AA55AA, 0, 1, 0, 0, 0, 32'hAC430011, 32'h0,        0, 1, 16'h0002, 32'h0,    4'h0, 0, 32'h0,        32'h0};
    vecs[9] = '{32'h126, 32'h4003, 32'h000000AB, 0, 0, 1, 0, 0, 32'hA0A74003, 32'h0,        4, 0, 16'h000A, 32'h4000, 4'h8, 1, 32'hABABABAB, 32'h0};

    // Reset state, sampled in the idle cycle right after release.
    do_reset();
    check("rst inst", inst, 32'h0);
    check("rst load_data", load_data, 32'h0);
    check("rst step", {31'b0, step}, 32'd0);
    check("rst halted", {31'b0, halted}, 32'd0);
    check("rst bus_error", {31'b0, bus_error}, 32'd0);
    check("rst mem_req", {31'b0, bus.mem_req}, 32'd0);
    check("rst mem_we", {31'b0, bus.mem_we}, 32'd0);
    check("rst mem_be", {28'b0, bus.mem_be}, 32'd0);
    check("rst mem_addr", bus.mem_addr, 32'h0);
    check("rst mem_wdata", bus.mem_wdata, 32'h0);
    tick();
    check("first req after reset", {31'b0, bus.mem_req}, 32'd1);

    for (int i = 0; i < 10; i++) run_vec(i);

    // Fetch with wait states, reset pulse in the second wait cycle.
    pc = 32'h200; data_addr = '0; store_data = '0;
    mem_read = 0; word_we = 0; byte_we = 0; byte_load = 0; except_in = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'hBAD0BAD0;
    do_reset();
    tick();
    check("wait c1 addr", bus.mem_addr, 32'h200);
    tick();
    check("wait c2 req", {31'b0, bus.mem_req}, 32'd1);
    #1 reset = 1'b1;
    #1 check("reset drops req", {31'b0, bus.mem_req}, 32'd0);
    check("reset no step", {31'b0, step}, 32'd0);
    #1 reset = 1'b0;
    pc = 32'h240;
    bus.mem_rdata = 32'h00001234;
    tick();
    check("restart req", {31'b0, bus.mem_req}, 32'd1);
    check("restart addr", bus.mem_addr, 32'h240);
    check("aborted inst discarded", inst, 32'h0);
    step_cyc = 0; unstable = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 4) bus.mem_ready = 1'b1;
      if (c <= 4 && (!bus.mem_req || bus.mem_addr != 32'h240 || bus.mem_we)) unstable++;
      if (step) begin
        step_cyc = c;
        break;
      end
      tick();
    end
    check("wait req stable", unstable, 0);
    check("wait step cycle", step_cyc, 6);
    check("wait inst", inst, 32'h00001234);

`ifdef MEM_TIMEOUT_EN
    // Memory never answers: abort after 16 wait cycles.
    pc = 32'h300;
    bus.mem_ready = 1'b0;
    do_reset();
    tick();
    nreq = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus_error) break;
      if (bus.mem_req) nreq++;
      tick();
    end
    check("timeout wait cycles", nreq, 16);
    check("timeout bus_error", {31'b0, bus_error}, 32'd1);
    check("timeout halted", {31'b0, halted}, 32'd1);
    check("timeout req dropped", {31'b0, bus.mem_req}, 32'd0);
    tick(); tick();
    check("timeout stays quiet", {30'b0, bus.mem_req, step}, 32'd0);
`else
    // Without the timeout the sequencer keeps waiting.
    pc = 32'h300;
    bus.mem_ready = 1'b0;
    do_reset();
    tick();
    nreq = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.mem_req && bus.mem_addr == 32'h300) nreq++;
      tick();
    end
    check("no-timeout wait cycles", nreq, 40);
    check("no-timeout bus_error", {31'b0, bus_error}, 32'd0);
    check("no-timeout halted", {31'b0, halted}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
